// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port
// between N_REQ requesters, with a registered write-enable/address/data stage.
module regfile_write_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int ZERO_RO = 1,
    parameter int SRC_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      stall,
    output logic                      wr_ena,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [SRC_W-1:0]          wr_src
);
    logic [SRC_W-1:0]  ptr_q, ptr_d, gnt_idx, wr_src_q, wr_src_d;
    logic              gnt_found, xfer, wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0] sel_addr, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] sel_data, wr_data_q, wr_data_d;

    // p + k modulo N_REQ; explicit wrap so non-power-of-two counts stay in range
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return SRC_W'(s);
    endfunction

    // first valid requester at or after the priority pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req_valid[wrap_add(ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(ptr_q, k);
            end
        end
        req_ready = (gnt_found && !stall && !rst) ? (N_REQ'(1) << gnt_idx) : '0;
        xfer      = |req_ready;
    end

    // route the granted requester's address and data to the output stage
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // next pointer and write stage; address 0 completes but is not written when read-only
    always_comb begin
        ptr_d     = xfer ? wrap_add(gnt_idx, 1) : ptr_q;
        wr_ena_d  = xfer && !(ZERO_RO != 0 && sel_addr == '0);
        wr_addr_d = xfer ? sel_addr : wr_addr_q;
        wr_data_d = xfer ? sel_data : wr_data_q;
        wr_src_d  = xfer ? gnt_idx : wr_src_q;
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign wr_ena  = wr_ena_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of the 4-requester arbiter (ZERO_RO=1 and 0)
// plus a randomized 3-requester build checked against hand-written rules.
module tb_regfile_write_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [19:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready, ready_z;
    logic         wr_ena, wr_ena_z;
    logic [4:0]   wr_addr, wr_addr_z;
    logic [31:0]  wr_data, wr_data_z;
    logic [1:0]   wr_src, wr_src_z;

    logic         stall3 = 1'b0;
    logic [2:0]   v3 = '0;
    logic [14:0]  a3 = '0;
    logic [95:0]  d3 = '0;
    logic [2:0]   r3;
    logic         wr_ena3;
    logic [4:0]   wr_addr3;
    logic [31:0]  wr_data3;
    logic [1:0]   wr_src3;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .stall(stall), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_src(wr_src)
    );

    regfile_write_arbiter #(.ZERO_RO(0)) dut_z0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(ready_z), .stall(stall), .wr_ena(wr_ena_z), .wr_addr(wr_addr_z),
        .wr_data(wr_data_z), .wr_src(wr_src_z)
    );

    regfile_write_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_addr(a3), .req_data(d3),
        .req_ready(r3), .stall(stall3), .wr_ena(wr_ena3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .wr_src(wr_src3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_reqs();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5]   = 5'(i + 1);
            req_data[i*32 +: 32] = 32'h100 + 32'(i);
        end
    endtask

    int          w[3];
    logic        exp_v;
    logic [1:0]  exp_g;
    logic [4:0]  exp_a, last_a;
    logic [31:0] exp_d, last_d;

    initial begin
        // reset state with all requesters asserting
        set_default_reqs();
        req_valid = 4'b1111;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ena", 32'(wr_ena), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        chk("rst_data", wr_data, 0);
        chk("rst_src", 32'(wr_src), 0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);

        // round robin over all four requesters
        for (int c = 0; c < 8; c++) begin
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            tick();
            chk("rr_ena", 32'(wr_ena), 1);
            chk("rr_src", 32'(wr_src), 32'(c % 4));
            chk("rr_addr", 32'(wr_addr), 32'(c % 4 + 1));
            chk("rr_data", wr_data, 32'h100 + 32'(c % 4));
        end

        // move ptr to 2, then only req 0 and 1 valid: wrap to 0, then 1
        req_valid = 4'b0010;
        #1;
        chk("skip_r1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("wrap_r0", 32'(req_ready), 32'h1);
        tick();
        chk("wrap_src0", 32'(wr_src), 0);
        #1;
        chk("next_r1", 32'(req_ready), 32'h2);
        tick();
        chk("next_src1", 32'(wr_src), 1);

        // stall with all valid for three cycles; ptr stays at 2
        req_valid = 4'b1111;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 0);
            tick();
            chk("stall_ena", 32'(wr_ena), 0);
            chk("stall_src_hold", 32'(wr_src), 1);
            chk("stall_addr_hold", 32'(wr_addr), 2);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'h4);
        tick();
        chk("unstall_src", 32'(wr_src), 2);
        chk("unstall_ena", 32'(wr_ena), 1);

        // x0 write from req 1: handshake completes, ptr advances, no write when read-only
        req_valid = 4'b0010;
        req_addr[5 +: 5] = 5'd0;
        req_data[32 +: 32] = 32'hDEADBEEF;
        #1;
        chk("x0_ready", 32'(req_ready), 32'h2);
        tick();
        chk("x0_ena", 32'(wr_ena), 0);
        chk("x0_data", wr_data, 32'hDEADBEEF);
        chk("x0_src", 32'(wr_src), 1);
        chk("x0rw_ena", 32'(wr_ena_z), 1);
        chk("x0rw_addr", 32'(wr_addr_z), 0);
        chk("x0rw_data", wr_data_z, 32'hDEADBEEF);
        set_default_reqs();
        req_valid = 4'b0110;
        #1;
        chk("x0_ptr_adv", 32'(req_ready), 32'h4);
        tick();
        chk("x0_after_ena", 32'(wr_ena), 1);

        // asynchronous reset mid-cycle while busy
        req_valid = 4'b1111;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ena", 32'(wr_ena), 0);
        chk("arst_addr", 32'(wr_addr), 0);
        chk("arst_data", wr_data, 0);
        chk("arst_src", 32'(wr_src), 0);
        chk("arst_ready", 32'(req_ready), 0);
        tick();
        chk("arst_hold_ena", 32'(wr_ena), 0);
        rst = 1'b0;
        #1;
        chk("arst_first", 32'(req_ready), 32'h1);
        tick();
        chk("arst_src0", 32'(wr_src), 0);
        chk("arst_ena1", 32'(wr_ena), 1);
        req_valid = '0;

        // random traffic on the 3-requester build
        w = '{0, 0, 0};
        last_a = '0;
        last_d = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v3[i] && $urandom_range(0, 1) == 1) begin
                    v3[i] = 1'b1;
                    a3[i*5 +: 5] = 5'($urandom_range(0, 31));
                    d3[i*32 +: 32] = $urandom;
                end
            end
            stall3 = ($urandom_range(0, 4) == 0);
            #1;
            chk("r3_onehot0", 32'($countones(r3) <= 1), 1);
            chk("r3_valid_only", 32'(r3 & ~v3), 0);
            if (stall3) chk("r3_stall", 32'(r3), 0);
            exp_v = |r3;
            exp_g = r3[1] ? 2'd1 : (r3[2] ? 2'd2 : 2'd0);
            exp_a = a3[exp_g*5 +: 5];
            exp_d = d3[exp_g*32 +: 32];
            for (int i = 0; i < 3; i++) begin
                if (r3[i]) w[i] = 0;
                else if (v3[i] && !stall3) w[i]++;
                if (v3[i]) chk("r3_fair", 32'(w[i] < 3), 1);
            end
            tick();
            chk("r3_ena", 32'(wr_ena3), 32'(exp_v && exp_a != 0));
            if (exp_v) begin
                chk("r3_src", 32'(wr_src3), 32'(exp_g));
                last_a = exp_a;
                last_d = exp_d;
                v3[exp_g] = 1'b0;
            end
            chk("r3_addr", 32'(wr_addr3), 32'(last_a));
            chk("r3_data", wr_data3, last_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
